transmision_ps2: RTL
====================

# transmision_ps2

Host-to-device PS/2 transmitter for the prevention unit. It sends one command byte (for example 0xED set-LEDs or 0xF4 enable) to the keyboard over the same two open-drain lines that the PS/2 receiver listens on. It also tells that receiver to stay idle while a frame is on the wire. The transmitter sits beside the receiver and keyboard-capture logic at the top level, and the capture logic or the FSM drives it.

## Interface
- CLK_HZ, 50_000_000, system clock frequency (documentation only)
- INHIBIT_CYCLES, 6000, cycles ps2c is held low for request-to-send (120 µs at 50 MHz)
- TIMEOUT_CYCLES, 750_000, maximum cycles to wait for any device clock edge (15 ms)
- clk  in  1  system clock; every register updates on the rising edge
- reset  in  1  synchronous, active-high reset
- wr_ps2  in  1  one-cycle strobe: start sending din; accepted only when tx_idle=1
- din  in  8  byte to send; latched on the accepted strobe
- ps2c  inout  1  PS/2 clock, open drain: driven 0 or high-Z, never driven 1
- ps2d  inout  1  PS/2 data, open drain: driven 0 or high-Z, never driven 1
- rx_en  out  1  1 when the receiver may run; equals tx_idle
- tx_idle  out  1  1 in the idle state
- tx_done_tick  out  1  one-cycle pulse when a frame ends, whether it succeeded or failed
- tx_err  out  1  result of the last frame: 1 = no ack or timeout; held until the next accepted strobe

## Operation
- ps2c input filter
  - 8-bit shift register samples ps2c each cycle.
  - Filtered level goes to 1 when all 8 samples are 1 and to 0 when all 8 are 0; otherwise it holds.
  - fall_edge is 1 for exactly one cycle when the filtered level goes 1→0.
- Frame latch: on an accepted strobe, latch {parity, din} with odd parity, parity = ~^din. Bit counter n is set to 8.
- State: idle
  - Both lines are high-Z.
  - wr_ps2=1 → rts, and tx_err is cleared.
  - wr_ps2 in any other state is ignored.
- State: rts
  - Drive ps2c=0 for INHIBIT_CYCLES cycles, then → start.
- State: start
  - Drive ps2d=0 (start bit) and release ps2c.
  - On fall_edge → data.
- State: data
  - ps2d drives the shift register LSB, which is d0 first on entry.
  - Each fall_edge shifts right by one and decrements n.
  - On fall_edge with n=0 (parity bit has been presented) → stop.
  - Drive order: d0..d7, then parity.
- State: stop
  - Release ps2d (stop bit = 1 through the pull-up).
  - On fall_edge → ack.
- State: ack
  - Lines high-Z.
  - On fall_edge, sample ps2d: 0 sets tx_err=0, 1 sets tx_err=1. Then pulse tx_done_tick → idle.
- Timeout
  - A counter resets on every fall_edge and on entry to start.
  - If it reaches TIMEOUT_CYCLES in start, data, stop or ack: tx_err=1, tx_done_tick pulses, both lines are released, → idle.
- Open-drain outputs: ps2c = c_oe ? 0 : Z, and ps2d = d_oe ? (d_bit ? Z : 0) : Z. Both enables are registered.

## Timing
- Reset values:
  - state = idle
  - ps2c and ps2d high-Z
  - rx_en = 1, tx_idle = 1, tx_done_tick = 0, tx_err = 0
  - filter register all 1s
  - counters 0
- Reset in the middle of a frame: on the next clock edge both lines are released and the block is in idle. No tx_done_tick is generated.
- Strobe timing:
  - The strobe is accepted in cycle T.
  - tx_idle and rx_en fall at T+1.
  - ps2c is driven low from T+1 through T+INHIBIT_CYCLES.
  - ps2d is driven low from T+INHIBIT_CYCLES+1.
- Data lines change one clk after the fall_edge cycle. With the filter, that is at most 10 clk after the physical ps2c falling edge.
- tx_done_tick is asserted in the cycle the block returns to idle. tx_idle and rx_en rise in that same cycle.
- A wr_ps2 in the same cycle as tx_done_tick is ignored. A strobe is accepted from the following cycle on.
- Glitches shorter than 8 cycles on ps2c produce no fall_edge.

## Test plan
- Send din=0xED, with a bench device model using pull-ups and a 12.5 kHz clock, that acks → ps2c low for 6000 cycles. ps2d sequence on falls: 1,0,1,1,0,1,1,1, parity 1, stop 1. Then tx_done_tick=1 and tx_err=0.
- Send din=0xF4 → bits 0,0,1,0,1,1,1,1, parity 0. rx_en=0 for the whole frame and 1 after tx_done_tick.
- Device model does not pull ps2d low in the ack slot → tx_done_tick with tx_err=1, and the lines are released.
- Device model never clocks after rts → TIMEOUT_CYCLES after entering start: tx_err=1, tx_done_tick=1, tx_idle=1.
- Assert reset in data after 4 bits → next edge: ps2c and ps2d high-Z, tx_idle=1, tx_err=0, no tx_done_tick. A new wr_ps2 with 0xF4 then sends cleanly.
- Inject 5-cycle low glitches on ps2c during data, and a second wr_ps2 during rts → no extra bit shifted and the frame is unchanged.

Source files
------------

// File: rtl/transmision_ps2.sv
// Host-to-device PS/2 transmitter: request-to-send, then shifts one byte with odd parity out
// on the device-generated clock and checks the device acknowledge.
module transmision_ps2 #(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned TIMEOUT_CYCLES = 750_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2c,
  inout  wire        ps2d,
  output logic       rx_en,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err
);

  localparam int unsigned CntMax = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES
                                                                     : INHIBIT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRts   = 3'd1;
  localparam logic [2:0] StStart = 3'd2;
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StStop  = 3'd4;
  localparam logic [2:0] StAck   = 3'd5;

  if (CLK_HZ == 0 || INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("transmision_ps2: invalid timing parameters");
  end

  logic [2:0]      state_q, state_d;
  logic [7:0]      filt_q, filt_d;
  logic            fval_q, fval_d;
  logic            fall_edge;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      n_q, n_d;
  logic [8:0]      b_q, b_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            c_oe_q, c_oe_d;
  logic            d_oe_q, d_oe_d;
  logic            d_bit_q, d_bit_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      filt_q  <= 8'hFF;
      fval_q  <= 1'b1;
      cnt_q   <= '0;
      n_q     <= '0;
      b_q     <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      c_oe_q  <= 1'b0;
      d_oe_q  <= 1'b0;
      d_bit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      fval_q  <= fval_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      b_q     <= b_d;
      err_q   <= err_d;
      done_q  <= done_d;
      c_oe_q  <= c_oe_d;
      d_oe_q  <= d_oe_d;
      d_bit_q <= d_bit_d;
    end
  end

  // Level changes only after 8 identical samples, so short glitches never make an edge.
  always_comb begin
    filt_d = {ps2c, filt_q[7:1]};
    if (filt_d == 8'hFF)      fval_d = 1'b1;
    else if (filt_d == 8'h00) fval_d = 1'b0;
    else                      fval_d = fval_q;
    fall_edge = fval_q & ~fval_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    b_d     = b_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        // The cycle that reports the previous frame does not accept a new one.
        if (wr_ps2 && !done_q) begin
          b_d     = {~^din, din};
          n_d     = 4'd8;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = StRts;
        end
      end
      StRts: begin
        if (cnt_q == CntW'(INHIBIT_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StStart;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStart, StData, StStop, StAck: begin
        if (fall_edge) begin
          cnt_d = '0;
          case (state_q)
            StStart: state_d = StData;
            StData: begin
              if (n_q == 4'd0) begin
                state_d = StStop;
              end else begin
                b_d = {1'b0, b_q[8:1]};
                n_d = n_q - 4'd1;
              end
            end
            StStop:  state_d = StAck;
            default: begin
              err_d   = ps2d;
              done_d  = 1'b1;
              state_d = StIdle;
            end
          endcase
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line enables follow the next state so the pins are registered with it.
  always_comb begin
    c_oe_d  = (state_d == StRts);
    d_oe_d  = (state_d == StStart) || (state_d == StData);
    d_bit_d = (state_d == StData) ? b_d[0] : 1'b0;
  end

  assign ps2c = c_oe_q ? 1'b0 : 1'bz;
  assign ps2d = d_oe_q ? (d_bit_q ? 1'bz : 1'b0) : 1'bz;

  assign tx_idle      = (state_q == StIdle);
  assign rx_en        = tx_idle;
  assign tx_done_tick = done_q;
  assign tx_err       = err_q;

endmodule
